// File: rtl/renkon_layer_seq_if.sv
// Handshake and configuration bundle between the host/core and the layer sequencer.
// master: the sequencer's view. slave: the host/core view driving the sequencer.
interface renkon_layer_seq_if #(
  parameter int NLAYER         = 8,
  parameter int LWIDTH         = 16,
  parameter int MEMSIZE        = 16,
  parameter int RENKON_NETSIZE = 16
);
  localparam int NLAYERLOG = (NLAYER > 1) ? $clog2(NLAYER) : 1;

  logic                      start;
  logic [NLAYERLOG:0]        num_layers;
  logic                      tbl_we;
  logic [NLAYERLOG-1:0]      tbl_addr;
  logic [LWIDTH-1:0]         tbl_total_out;
  logic [LWIDTH-1:0]         tbl_total_in;
  logic [LWIDTH-1:0]         tbl_img_size;
  logic [LWIDTH-1:0]         tbl_conv_kern;
  logic [MEMSIZE-1:0]        tbl_in_offset;
  logic [MEMSIZE-1:0]        tbl_out_offset;
  logic [RENKON_NETSIZE-1:0] tbl_net_offset;
  logic                      ack;

  logic                      req;
  logic [LWIDTH-1:0]         total_out;
  logic [LWIDTH-1:0]         total_in;
  logic [LWIDTH-1:0]         img_size;
  logic [LWIDTH-1:0]         conv_kern;
  logic [MEMSIZE-1:0]        in_offset;
  logic [MEMSIZE-1:0]        out_offset;
  logic [RENKON_NETSIZE-1:0] net_offset;
  logic [NLAYERLOG-1:0]      cur_layer;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    input  start, num_layers, tbl_we, tbl_addr,
           tbl_total_out, tbl_total_in, tbl_img_size, tbl_conv_kern,
           tbl_in_offset, tbl_out_offset, tbl_net_offset, ack,
    output req, total_out, total_in, img_size, conv_kern,
           in_offset, out_offset, net_offset, cur_layer, busy, done, err
  );

  modport slave (
    output start, num_layers, tbl_we, tbl_addr,
           tbl_total_out, tbl_total_in, tbl_img_size, tbl_conv_kern,
           tbl_in_offset, tbl_out_offset, tbl_net_offset, ack,
    input  req, total_out, total_in, img_size, conv_kern,
           in_offset, out_offset, net_offset, cur_layer, busy, done, err
  );
endinterface

// File: rtl/renkon_layer_seq.sv
// Layer sequencer: walks a small table of per-layer parameters, issuing one req per
// layer to the core and waiting for ack; a watchdog aborts a layer that never acks.
//
//   state | meaning
//   IDLE  | waiting for start; table writable
//   ISSUE | req high for one cycle, params already valid
//   WAIT  | params held, waiting for ack, watchdog counting
//   DONE  | one-cycle done pulse; table writable
module renkon_layer_seq #(
  parameter int NLAYER         = 8,
  parameter int TIMEOUT        = 65536,
  parameter int LWIDTH         = 16,
  parameter int MEMSIZE        = 16,
  parameter int RENKON_NETSIZE = 16
) (
  input logic                clk,
  input logic                rst,
  renkon_layer_seq_if.master bus
);
  localparam int NLAYERLOG = (NLAYER > 1) ? $clog2(NLAYER) : 1;
  localparam int WDW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]       WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [NLAYERLOG:0]   NL_MAX  = (NLAYERLOG + 1)'(NLAYER);

  typedef struct packed {
    logic [LWIDTH-1:0]         total_out;
    logic [LWIDTH-1:0]         total_in;
    logic [LWIDTH-1:0]         img_size;
    logic [LWIDTH-1:0]         conv_kern;
    logic [MEMSIZE-1:0]        in_offset;
    logic [MEMSIZE-1:0]        out_offset;
    logic [RENKON_NETSIZE-1:0] net_offset;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  entry_t               r_tbl [NLAYER];
  entry_t               r_par;
  logic [WDW-1:0]       r_wdog;
  logic [NLAYERLOG-1:0] r_cur;
  logic [NLAYERLOG-1:0] r_last;
  logic                 r_req;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  entry_t               w_wr_ent;
  entry_t               w_entry0;
  logic                 w_tbl_wr;
  logic [NLAYERLOG:0]   w_num;
  logic [NLAYERLOG-1:0] w_next_idx;

  assign w_wr_ent = {bus.tbl_total_out, bus.tbl_total_in, bus.tbl_img_size, bus.tbl_conv_kern,
                     bus.tbl_in_offset, bus.tbl_out_offset, bus.tbl_net_offset};
  assign w_tbl_wr = bus.tbl_we && ((r_state == S_IDLE) || (r_state == S_DONE));
  // A write to entry 0 on the start edge must be seen by the first layer.
  assign w_entry0 = (w_tbl_wr && (bus.tbl_addr == '0)) ? w_wr_ent : r_tbl[0];
  assign w_num = (bus.num_layers > NL_MAX) ? NL_MAX : bus.num_layers;
  assign w_next_idx = r_cur + 1'b1;

  // Parameter table: written only while not running, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_tbl_wr && (int'(bus.tbl_addr) < NLAYER)) r_tbl[bus.tbl_addr] <= w_wr_ent;
  end

  // Sequencer FSM with registered outputs and WAIT watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_par   <= '0;
      r_wdog  <= '0;
      r_cur   <= '0;
      r_last  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_err <= 1'b0;
            r_cur <= '0;
            if (w_num == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_last  <= NLAYERLOG'(w_num - 1'b1);
              r_par   <= w_entry0;
              r_req   <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_req   <= 1'b0;
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // ack beats the watchdog when both land on the same cycle.
          if (bus.ack) begin
            if (r_cur == r_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cur   <= w_next_idx;
              r_par   <= r_tbl[w_next_idx];
              r_req   <= 1'b1;
              r_state <= S_ISSUE;
            end
          end else if (r_wdog == WD_LAST) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req        = r_req;
  assign bus.total_out  = r_par.total_out;
  assign bus.total_in   = r_par.total_in;
  assign bus.img_size   = r_par.img_size;
  assign bus.conv_kern  = r_par.conv_kern;
  assign bus.in_offset  = r_par.in_offset;
  assign bus.out_offset = r_par.out_offset;
  assign bus.net_offset = r_par.net_offset;
  assign bus.cur_layer  = r_cur;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
endmodule
